// File: rtl/tcm_pkg.sv
// Shared definitions for the two-counter machine sequencer: ALU opcodes,
// instruction set opcodes, instruction field positions and FSM states.
package tcm_pkg;

  // Opcodes understood by the shared external 8-bit ALU
  localparam logic [2:0] ALU_ZERO  = 3'b000;
  localparam logic [2:0] ALU_INC   = 3'b001;
  localparam logic [2:0] ALU_DEC   = 3'b010;
  localparam logic [2:0] ALU_PASSA = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;

  // Instruction opcodes (110 and 111 are illegal and behave as NOP)
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_JZDEC = 3'b010;
  localparam logic [2:0] OP_CLR   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b101;

  // Instruction field positions; the jump target occupies [PC_W-1:0]
  localparam int INSTR_W = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int REG_BIT = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/tcm_decode.sv
// Combinational instruction decoder: splits the latched instruction into
// opcode, register select and jump target, and flags HALT / illegal opcodes.
module tcm_decode
  import tcm_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [2:0]         op,
  output logic               r,
  output logic [PC_W-1:0]    target,
  output logic               is_halt,
  output logic               is_illegal
);

  // Field extraction; bits between the register bit and the target are don't-care
  always_comb begin
    op         = instr[OP_HI:OP_LO];
    r          = instr[REG_BIT];
    target     = instr[PC_W-1:0];
    is_halt    = (instr[OP_HI:OP_LO] == OP_HALT);
    is_illegal = is_illegal_op(instr[OP_HI:OP_LO]);
  end

  if (PC_W < REG_BIT) begin : g_unused_bits
    logic unused_hi;
    assign unused_hi = ^instr[REG_BIT-1:PC_W];
  end

endmodule

// File: rtl/tcm_sequencer.sv
// Two-counter machine sequencer. Fetches 16-bit instructions from an external
// memory with one cycle of read latency, drives the shared external ALU to
// update counters A/B, and stops on HALT or after MAX_STEPS executed
// instructions. Every instruction takes FETCH, WAIT and EXEC (3 cycles).
//
//   state    | meaning
//   ST_IDLE  | waiting for start; counters and flags hold last results
//   ST_FETCH | read strobe high, address = PC
//   ST_WAIT  | memory data arrives, captured into the instruction register
//   ST_EXEC  | ALU result written back, PC and step count advance
//   ST_DONE  | one-cycle done pulse, then back to idle
module tcm_sequencer
  import tcm_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int MAX_STEPS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         init_a,
  input  logic [7:0]         init_b,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               overflow,
  output logic [7:0]         result_a,
  output logic [7:0]         result_b,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [2:0]         alu_op,
  input  logic [7:0]         alu_result
);

  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [7:0]           cnt_a_q, cnt_a_d;
  logic [7:0]           cnt_b_q, cnt_b_d;
  logic [15:0]          steps_q, steps_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 overflow_q, overflow_d;
  logic                 rd_en_q, rd_en_d;

  logic [2:0]           dec_op;
  logic                 dec_r;
  logic [PC_W-1:0]      dec_target;
  logic                 dec_halt;
  logic                 dec_illegal;

  logic [7:0]           sel_cnt;
  logic [2:0]           alu_op_c;
  logic                 wr_en;
  logic [15:0]          steps_inc;

  tcm_decode #(
    .PC_W(PC_W)
  ) u_decode (
    .instr      (instr_q),
    .op         (dec_op),
    .r          (dec_r),
    .target     (dec_target),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign sel_cnt   = dec_r ? cnt_b_q : cnt_a_q;
  assign steps_inc = steps_q + 16'd1;

  // ALU opcode and counter write enable for the instruction being executed;
  // the JZDEC zero test looks at the counter itself, so DEC never underflows
  always_comb begin
    alu_op_c = ALU_PASSA;
    wr_en    = 1'b0;
    if (state_q == ST_EXEC && !dec_illegal) begin
      case (dec_op)
        OP_INC: begin
          alu_op_c = ALU_INC;
          wr_en    = 1'b1;
        end
        OP_JZDEC: begin
          if (sel_cnt != 8'd0) begin
            alu_op_c = ALU_DEC;
            wr_en    = 1'b1;
          end
        end
        OP_CLR: begin
          alu_op_c = ALU_ZERO;
          wr_en    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and next-register computation for the sequencing FSM
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    steps_d    = steps_q;
    instr_d    = instr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          cnt_a_d    = init_a;
          cnt_b_d    = init_b;
          pc_d       = '0;
          steps_d    = '0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        instr_d = imem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        steps_d = steps_inc;
        pc_d    = pc_q + 1'b1;
        if (wr_en) begin
          if (dec_r) cnt_b_d = alu_result;
          else       cnt_a_d = alu_result;
        end
        if (dec_op == OP_INC && sel_cnt == 8'hFF) overflow_d = 1'b1;
        if (dec_op == OP_JMP || (dec_op == OP_JZDEC && sel_cnt == 8'd0)) pc_d = dec_target;
        if (dec_halt) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (steps_inc == STEP_LIMIT) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rd_en_d = (state_d == ST_FETCH);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      steps_q    <= '0;
      instr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      steps_q    <= steps_d;
      instr_q    <= instr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
  assign result_a   = cnt_a_q;
  assign result_b   = cnt_b_q;
  assign imem_rd_en = rd_en_q;
  assign imem_addr  = pc_q;
  assign alu_a      = (state_q == ST_EXEC) ? sel_cnt : cnt_a_q;
  assign alu_b      = cnt_b_q;
  assign alu_op     = alu_op_c;

endmodule

// File: tb/tb_tcm_sequencer.sv
// Bench for tcm_sequencer: an instruction-level interpreter predicts the
// fetch address sequence, ALU drive per instruction and final results; a
// negedge monitor compares the DUT against it every cycle of a run.
module tb_tcm_sequencer;
  localparam int PC_W = 8;
  localparam int MAXS = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      init_a = 8'd0;
  logic [7:0]      init_b = 8'd0;
  logic            busy, done, timeout, overflow;
  logic [7:0]      result_a, result_b;
  logic            imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [7:0]      alu_a, alu_b;
  logic [2:0]      alu_op;
  logic [7:0]      alu_result;

  logic [15:0]     imem [0:255];

  int n_total = 0;
  int n_pass  = 0;

  int exp_n, exp_a, exp_b, exp_ovf, exp_to;
  int exp_pc   [MAXS];
  int exp_op   [MAXS];
  int exp_alua [MAXS];
  int exp_alub [MAXS];

  bit mon_on  = 1'b0;
  bit mon_fin = 1'b0;
  int mon_cyc = 0;
  int mon_done_cyc = 0;
  int mon_k, mon_ph;

  always #5 clk = ~clk;

  tcm_sequencer #(.PC_W(PC_W), .MAX_STEPS(MAXS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_a     (init_a),
    .init_b     (init_b),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .overflow   (overflow),
    .result_a   (result_a),
    .result_b   (result_b),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  // External ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = 8'd0;
      3'b001:  alu_result = alu_a + 8'd1;
      3'b010:  alu_result = alu_a - 8'd1;
      3'b011:  alu_result = alu_a;
      3'b100:  alu_result = alu_b;
      3'b101:  alu_result = alu_a - alu_b;
      default: alu_result = 8'd0;
    endcase
  end

  // Instruction memory, one cycle read latency; junk when not strobed
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= imem[imem_addr];
    else            imem_data <= 16'($urandom);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] mk(input int op, input int r, input int tgt);
    return 16'((op << 13) | (r << 12) | (tgt & 255));
  endfunction

  // Instruction-level interpreter of the program currently in imem
  task automatic run_model(input int a0, input int b0);
    int a, b, pc, steps, op, r, tgt, val, npc;
    bit fin;
    logic [15:0] ins;
    a = a0; b = b0; pc = 0; steps = 0; fin = 0;
    exp_ovf = 0; exp_to = 0;
    while (!fin) begin
      ins = imem[pc];
      op  = int'(ins[15:13]);
      r   = int'(ins[12]);
      tgt = int'(ins[7:0]);
      val = (r != 0) ? b : a;
      exp_pc[steps]   = pc;
      exp_alua[steps] = val;
      exp_alub[steps] = b;
      exp_op[steps]   = 3;
      npc = (pc + 1) % 256;
      case (op)
        1: begin exp_op[steps] = 1; if (val == 255) exp_ovf = 1; val = (val + 1) % 256; end
        2: if (val == 0) npc = tgt; else begin exp_op[steps] = 2; val = val - 1; end
        3: begin exp_op[steps] = 0; val = 0; end
        4: npc = tgt;
        default: ;
      endcase
      if (r != 0) b = val; else a = val;
      steps++;
      if (op == 5) fin = 1;
      else if (steps == MAXS) begin exp_to = 1; fin = 1; end
      pc = npc;
    end
    exp_n = steps; exp_a = a; exp_b = b;
  endtask

  // Per-cycle comparison while a run is in progress
  always @(negedge clk) begin
    if (mon_on) begin
      mon_cyc++;
      mon_k  = (mon_cyc - 1) / 3;
      mon_ph = (mon_cyc - 1) % 3;
      if (mon_cyc <= 3 * exp_n) begin
        chk("busy_run", int'(busy), 1);
        chk("done_early", int'(done), 0);
        chk("rd_en", int'(imem_rd_en), int'(mon_ph == 0));
        if (mon_ph == 0) chk("fetch_addr", int'(imem_addr), exp_pc[mon_k]);
        if (mon_ph == 2) begin
          chk("alu_op_exec", int'(alu_op), exp_op[mon_k]);
          chk("alu_a_exec", int'(alu_a), exp_alua[mon_k]);
          chk("alu_b_exec", int'(alu_b), exp_alub[mon_k]);
        end else begin
          chk("alu_op_idle", int'(alu_op), 3);
        end
      end else begin
        chk("done_pulse", int'(done), 1);
        chk("busy_done", int'(busy), 0);
        chk("rd_en_done", int'(imem_rd_en), 0);
        chk("result_a", int'(result_a), exp_a);
        chk("result_b", int'(result_b), exp_b);
        chk("timeout", int'(timeout), exp_to);
        chk("overflow", int'(overflow), exp_ovf);
        mon_done_cyc = mon_cyc;
        mon_on  = 1'b0;
        mon_fin = 1'b1;
      end
    end
  end

  task automatic run_prog(input int a0, input int b0, input bit mid);
    run_model(a0, b0);
    mon_fin = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; init_a = 8'(a0); init_b = 8'(b0);
    @(posedge clk);
    mon_cyc = 0; mon_on = 1'b1;
    #1;
    start = 1'b0; init_a = 8'($urandom); init_b = 8'($urandom);
    for (int i = 1; i <= 3 * MAXS + 20 && !mon_fin; i++) begin
      if (mid && i == 2) begin #1 start = 1'b1; end
      if (mid && i == 3) begin #1 start = 1'b0; end
      @(posedge clk);
    end
    if (!mon_fin) begin
      chk("run_finished", 0, 1);
      mon_on = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic fill_imem(input int op);
    for (int i = 0; i < 256; i++) imem[i] = mk(op, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_imem(5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_rd_en", int'(imem_rd_en), 0);
    chk("rst_addr", int'(imem_addr), 0);
    chk("rst_alu_op", int'(alu_op), 3);
    chk("rst_res_a", int'(result_a), 0);
    chk("rst_res_b", int'(result_b), 0);
    rst = 1'b0;

    // Countdown loop moving A into B
    fill_imem(5);
    imem[0] = mk(2, 0, 3); imem[1] = mk(1, 1, 0); imem[2] = mk(4, 0, 0); imem[3] = mk(5, 0, 0);
    run_prog(3, 0, 0);
    chk("t1_model_n", exp_n, 11);
    chk("t1_res_a", int'(result_a), 0);
    chk("t1_res_b", int'(result_b), 3);

    // JZDEC taken on zero counter
    fill_imem(1);
    imem[0] = mk(2, 0, 5); imem[5] = mk(5, 0, 0);
    run_prog(0, 9, 0);
    chk("t2_model_n", exp_n, 2);
    chk("t2_res_a", int'(result_a), 0);
    chk("t2_done_cyc", mon_done_cyc, 7);

    // INC overflow, then cleared by the next start
    fill_imem(5);
    imem[0] = mk(1, 1, 0);
    run_prog(0, 255, 0);
    chk("t3_res_b", int'(result_b), 0);
    chk("t3_overflow", int'(overflow), 1);
    imem[0] = mk(5, 0, 0);
    run_prog(4, 4, 0);
    chk("t3_overflow_clr", int'(overflow), 0);

    // Endless loop hits the step limit
    fill_imem(5);
    imem[0] = mk(4, 0, 0);
    run_prog(1, 2, 1);
    chk("t4_model_n", exp_n, MAXS);
    chk("t4_timeout", int'(timeout), 1);
    chk("t4_done_cyc", mon_done_cyc, 3 * MAXS + 1);
    imem[0] = mk(5, 0, 0);
    run_prog(1, 2, 0);
    chk("t4_timeout_clr", int'(timeout), 0);

    // Reset in the WAIT cycle of the third instruction, with start held
    fill_imem(0);
    imem[3] = mk(5, 0, 0);
    @(posedge clk); #1;
    start = 1'b1; init_a = 8'd5; init_b = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t5_busy_before", int'(busy), 1);
    chk("t5_pc_before", int'(imem_addr), 2);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_res_a", int'(result_a), 0);
    chk("t5_res_b", int'(result_b), 0);
    chk("t5_pc", int'(imem_addr), 0);
    chk("t5_alu_op", int'(alu_op), 3);
    @(posedge clk); #1;
    chk("t5_rst_wins", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    run_prog(5, 7, 1);

    // Illegal opcodes behave as NOP
    fill_imem(5);
    imem[0] = mk(7, 1, 3); imem[1] = mk(6, 0, 0);
    run_prog(9, 4, 0);
    chk("t6_model_n", exp_n, 3);
    chk("t6_res_a", int'(result_a), 9);
    chk("t6_res_b", int'(result_b), 4);

    // PC wraps from 255 to 0
    fill_imem(5);
    imem[0] = mk(2, 0, 255); imem[255] = mk(1, 0, 0);
    run_prog(0, 0, 0);
    chk("wrap_model_n", exp_n, 4);
    chk("wrap_res_a", int'(result_a), 0);

    // Random programs with small jump targets and junk in the ignored bits
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++)
        imem[i] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 15))
                  | 16'($urandom_range(0, 15) << 8);
      if (t % 5 == 0) imem[0] = mk(1, $urandom_range(0, 1), 0);
      run_prog((t % 5 == 0) ? 255 : int'($urandom_range(0, 255)),
               (t % 5 == 0) ? 255 : int'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
